// File: rtl/mag_pkg.sv
// Shared definitions for the microwave cook timer.
//   bcd_digit_t          one BCD digit
//   TIME_ZERO/TIME_ONE   00:00 and 00:01 in {min_tens, min_ones, sec_tens, sec_ones}
//   TIME_MAX             99:59, saturation point of the +30 s adder
//   *_LSB                bit offset of each digit field in a 16-bit time word
//   clamp_time()         forces a raw preset into a legal MM:SS value
package mag_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] TIME_ZERO = 16'h0000;
  localparam logic [15:0] TIME_ONE  = 16'h0001;
  localparam logic [15:0] TIME_MAX  = 16'h9959;

  localparam int unsigned SEC_ONES_LSB = 0;
  localparam int unsigned SEC_TENS_LSB = 4;
  localparam int unsigned MIN_ONES_LSB = 8;
  localparam int unsigned MIN_TENS_LSB = 12;

  localparam bcd_digit_t DIGIT_MAX = 4'd9;
  localparam bcd_digit_t TENS_MAX  = 4'd5;

  // Non-decimal digits saturate at 9; seconds-tens additionally caps at 5.
  function automatic logic [15:0] clamp_time(input logic [15:0] raw);
    logic [15:0] res;
    bcd_digit_t  d;
    d = raw[MIN_TENS_LSB +: 4];
    res[MIN_TENS_LSB +: 4] = (d > DIGIT_MAX) ? DIGIT_MAX : d;
    d = raw[MIN_ONES_LSB +: 4];
    res[MIN_ONES_LSB +: 4] = (d > DIGIT_MAX) ? DIGIT_MAX : d;
    d = raw[SEC_TENS_LSB +: 4];
    res[SEC_TENS_LSB +: 4] = (d > TENS_MAX) ? TENS_MAX : d;
    d = raw[SEC_ONES_LSB +: 4];
    res[SEC_ONES_LSB +: 4] = (d > DIGIT_MAX) ? DIGIT_MAX : d;
    return res;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of a borrow-chained down counter.
//   digit       current digit value
//   borrow_in   decrement request from the less significant digit
//   wrap        value taken when decrementing from 0 (9, or 5 for seconds-tens)
//   digit_next  digit after the optional decrement
//   borrow_out  asserted when this digit wrapped and borrows from the next one
module bcd_digit_down
  import mag_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  input  bcd_digit_t wrap,
  output bcd_digit_t digit_next,
  output logic       borrow_out
);

  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = wrap;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/mag_timer.sv
// Microwave cook-time countdown in MM:SS BCD; drives timer_done of the magnetron latch.
//   clk, rst     clock and asynchronous active-high reset
//   clearn       synchronous active-low clear of time and prescaler
//   load         load the clamped load_bcd preset, restart the prescaler
//   load_bcd     preset {min_tens, min_ones, sec_tens, sec_ones}
//   enable       magnetron on; countdown and prescaler advance only while high
//   add30        +30 s strobe (only when MAG_TIMER_ADD30_EN is defined)
//   time_bcd     remaining time, registered
//   timer_done   high whenever time_bcd is 00:00
//   done_pulse   one-cycle pulse after a tick reaches 00:00
// Optional feature: define MAG_TIMER_ADD30_EN to build the add30 port and adder.
module mag_timer
  import mag_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clearn,
  input  logic        load,
  input  logic [15:0] load_bcd,
  input  logic        enable,
`ifdef MAG_TIMER_ADD30_EN
  input  logic        add30,
`endif
  output logic [15:0] time_bcd,
  output logic        timer_done,
  output logic        done_pulse
);

  localparam int unsigned PreW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_SEC - 1);

  logic [15:0]     time_q, time_d;
  logic [PreW-1:0] presc_q, presc_d;
  logic            done_pulse_q, done_pulse_d;

  logic        time_zero;
  logic        run;
  logic        tick;
  logic [15:0] time_dec;
  logic [3:0]  borrow;
  logic        borrow_top;

  assign time_zero = (time_q == TIME_ZERO);
  assign run       = enable && !time_zero;
  assign tick      = run && (presc_q == PreLast);
  assign borrow[0] = tick;

  bcd_digit_down u_sec_ones (
    .digit      (time_q[SEC_ONES_LSB +: 4]),
    .borrow_in  (borrow[0]),
    .wrap       (DIGIT_MAX),
    .digit_next (time_dec[SEC_ONES_LSB +: 4]),
    .borrow_out (borrow[1])
  );

  bcd_digit_down u_sec_tens (
    .digit      (time_q[SEC_TENS_LSB +: 4]),
    .borrow_in  (borrow[1]),
    .wrap       (TENS_MAX),
    .digit_next (time_dec[SEC_TENS_LSB +: 4]),
    .borrow_out (borrow[2])
  );

  bcd_digit_down u_min_ones (
    .digit      (time_q[MIN_ONES_LSB +: 4]),
    .borrow_in  (borrow[2]),
    .wrap       (DIGIT_MAX),
    .digit_next (time_dec[MIN_ONES_LSB +: 4]),
    .borrow_out (borrow[3])
  );

  bcd_digit_down u_min_tens (
    .digit      (time_q[MIN_TENS_LSB +: 4]),
    .borrow_in  (borrow[3]),
    .wrap       (DIGIT_MAX),
    .digit_next (time_dec[MIN_TENS_LSB +: 4]),
    .borrow_out (borrow_top)
  );

`ifdef MAG_TIMER_ADD30_EN
  logic [15:0] time_add30;
  bcd_digit_t  add_st, add_mo, add_mt;
  logic        carry_st, carry_mo;

  // +30 s only touches the seconds-tens digit and ripples upward; seconds-ones is kept.
  always_comb begin
    add_st   = time_q[SEC_TENS_LSB +: 4] + 4'd3;
    carry_st = (add_st > TENS_MAX);
    if (carry_st) begin
      add_st = add_st - 4'd6;
    end
    add_mo   = time_q[MIN_ONES_LSB +: 4] + {3'b000, carry_st};
    carry_mo = (add_mo > DIGIT_MAX);
    if (carry_mo) begin
      add_mo = 4'd0;
    end
    add_mt = time_q[MIN_TENS_LSB +: 4] + {3'b000, carry_mo};
    if (add_mt > DIGIT_MAX) begin
      time_add30 = TIME_MAX;
    end else begin
      time_add30 = {add_mt, add_mo, add_st, time_q[SEC_ONES_LSB +: 4]};
    end
  end
`endif

  always_comb begin
    time_d       = time_q;
    presc_d      = presc_q;
    done_pulse_d = 1'b0;
    if (!clearn) begin
      time_d  = TIME_ZERO;
      presc_d = '0;
    end else if (load) begin
      time_d  = clamp_time(load_bcd);
      presc_d = '0;
`ifdef MAG_TIMER_ADD30_EN
    end else if (add30) begin
      // Prescaler left alone so the partial second survives.
      time_d = time_add30;
`endif
    end else if (run) begin
      if (tick) begin
        presc_d      = '0;
        // A borrow out of the top digit would mean underflow; hold at zero instead.
        time_d       = borrow_top ? TIME_ZERO : time_dec;
        done_pulse_d = (time_q == TIME_ONE);
      end else begin
        presc_d = presc_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_q       <= TIME_ZERO;
      presc_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      time_q       <= time_d;
      presc_q      <= presc_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign time_bcd   = time_q;
  assign timer_done = time_zero;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_mag_timer.sv
// Self-checking bench for mag_timer with TICKS_PER_SEC = 4. The reference model keeps the
// remaining time as plain seconds and converts to BCD only for comparison.
module tb_mag_timer;

  localparam int Tps = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clearn;
  logic        load;
  logic [15:0] load_bcd;
  logic        enable;
  logic        add30;
  logic [15:0] time_bcd;
  logic        timer_done;
  logic        done_pulse;

  int n_checks = 0;
  int n_errors = 0;

  int m_secs;
  int m_pre;
  bit m_pulse;

  always #5 clk = ~clk;

  mag_timer #(
    .TICKS_PER_SEC (Tps)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clearn     (clearn),
    .load       (load),
    .load_bcd   (load_bcd),
    .enable     (enable),
`ifdef MAG_TIMER_ADD30_EN
    .add30      (add30),
`endif
    .time_bcd   (time_bcd),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp_secs(input logic [15:0] b);
    int mt, mo, st, so;
    mt = (b[15:12] > 9) ? 9 : int'(b[15:12]);
    mo = (b[11:8]  > 9) ? 9 : int'(b[11:8]);
    st = (b[7:4]   > 5) ? 5 : int'(b[7:4]);
    so = (b[3:0]   > 9) ? 9 : int'(b[3:0]);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic int to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return ((m / 10) << 12) | ((m % 10) << 8) | ((r / 10) << 4) | (r % 10);
  endfunction

  task automatic model_step();
    m_pulse = 1'b0;
    if (!clearn) begin
      m_secs = 0;
      m_pre  = 0;
    end else if (load) begin
      m_secs = clamp_secs(load_bcd);
      m_pre  = 0;
    end else if (add30) begin
      m_secs = (m_secs + 30 > 5999) ? 5999 : m_secs + 30;
    end else if (enable && m_secs > 0) begin
      if (m_pre == Tps - 1) begin
        m_pre   = 0;
        m_secs  = m_secs - 1;
        m_pulse = (m_secs == 0);
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    check("time_bcd", int'(time_bcd), to_bcd(m_secs));
    check("timer_done", int'(timer_done), int'(m_secs == 0));
    check("done_pulse", int'(done_pulse), int'(m_pulse));
  endtask

  task automatic idle_inputs();
    clearn = 1'b1;
    load   = 1'b0;
    add30  = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic en);
    idle_inputs();
    load     = 1'b1;
    load_bcd = v;
    enable   = en;
    cycle();
    load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst      = 1'b1;
    clearn   = 1'b1;
    load     = 1'b0;
    load_bcd = 16'h0000;
    enable   = 1'b0;
    add30    = 1'b0;
    m_secs   = 0;
    m_pre    = 0;
    m_pulse  = 1'b0;
    #12;
    check("reset_time", int'(time_bcd), 0);
    check("reset_done", int'(timer_done), 1);
    check("reset_pulse", int'(done_pulse), 0);
    rst = 1'b0;

    // 01:02 counts to 01:01, 01:00, 00:59 at 4-cycle spacing.
    do_load(16'h0102, 1'b1);
    run(4);
    check("cnt_4", int'(time_bcd), 16'h0101);
    run(4);
    check("cnt_8", int'(time_bcd), 16'h0100);
    run(4);
    check("cnt_12", int'(time_bcd), 16'h0059);

    // Asynchronous reset mid-count, no clock edge in between.
    run(2);
    #3;
    rst = 1'b1;
    #1;
    m_secs  = 0;
    m_pre   = 0;
    m_pulse = 1'b0;
    check("async_rst_time", int'(time_bcd), 0);
    check("async_rst_done", int'(timer_done), 1);
    check("async_rst_pulse", int'(done_pulse), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pause preserves the partial second.
    do_load(16'h0002, 1'b1);
    run(6);
    check("pre_pause", int'(time_bcd), 16'h0001);
    enable = 1'b0;
    run(10);
    check("paused", int'(time_bcd), 16'h0001);
    enable = 1'b1;
    cycle();
    check("reen_1", int'(time_bcd), 16'h0001);
    cycle();
    check("reen_2", int'(time_bcd), 16'h0000);
    check("reen_pulse", int'(done_pulse), 1);
    check("reen_done", int'(timer_done), 1);
    cycle();
    check("pulse_one_cycle", int'(done_pulse), 0);
    run(6);
    check("hold_zero", int'(time_bcd), 16'h0000);

    // Clear beats load; clamping of an illegal preset.
    idle_inputs();
    clearn   = 1'b0;
    load     = 1'b1;
    load_bcd = 16'h0000;
    cycle();
    check("clr_over_load", int'(time_bcd), 0);
    check("clr_no_pulse", int'(done_pulse), 0);
    do_load(16'hAB7C, 1'b0);
    check("clamp", int'(time_bcd), 16'h9959);
    do_load(16'h1234, 1'b1);
    clearn = 1'b0;
    load   = 1'b1;
    cycle();
    check("clr_over_load2", int'(time_bcd), 0);

    // Clear while running at 00:03.
    do_load(16'h0003, 1'b1);
    run(2);
    clearn = 1'b0;
    cycle();
    clearn = 1'b1;
    check("clr_run_time", int'(time_bcd), 0);
    check("clr_run_done", int'(timer_done), 1);
    check("clr_run_pulse", int'(done_pulse), 0);
    run(3);

`ifdef MAG_TIMER_ADD30_EN
    do_load(16'h0045, 1'b0);
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("add30_carry", int'(time_bcd), 16'h0115);
    do_load(16'h9950, 1'b0);
    add30 = 1'b1;
    cycle();
    add30 = 1'b0;
    check("add30_sat", int'(time_bcd), 16'h9959);
    clearn = 1'b0;
    cycle();
    clearn = 1'b1;
    add30  = 1'b1;
    cycle();
    add30 = 1'b0;
    check("add30_zero", int'(time_bcd), 16'h0030);
    check("add30_done", int'(timer_done), 0);
`endif

    // Randomized traffic against the model; short presets make zero crossings common.
    for (int i = 0; i < 3000; i++) begin
      clearn = ($urandom_range(0, 59) != 0);
      load   = ($urandom_range(0, 24) == 0);
      enable = ($urandom_range(0, 7) != 0);
`ifdef MAG_TIMER_ADD30_EN
      add30  = ($urandom_range(0, 39) == 0);
`endif
      if ($urandom_range(0, 2) == 0) load_bcd = 16'($urandom);
      else load_bcd = 16'($urandom_range(0, 9));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
